// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, one Booth step per clock, signed or unsigned operands.
// Optional BOOTH_ZERO_SKIP_EN: a zero operand completes straight from IDLE to DONE.
module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int DW = WIDTH + 1;
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] STEPS = CW'(DW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [DW-1:0] a_reg;
    logic [DW-1:0] q_reg;
    logic [DW-1:0] m_reg;
    logic          q_m1;
    logic [CW-1:0] count;

    logic [DW-1:0] ext_m;
    logic [DW-1:0] ext_q;
    logic [DW-1:0] a_sum;
    logic [DW-1:0] a_next;
    logic [DW-1:0] q_next;
    logic          q_m1_next;
    logic          accept;
    logic          last_step;
    logic          zero_op;

    // One extra bit lets the same signed Booth recoding cover unsigned operands.
    assign ext_m = signed_mode ? {multiplicand[WIDTH-1], multiplicand} : {1'b0, multiplicand};
    assign ext_q = signed_mode ? {multiplier[WIDTH-1], multiplier} : {1'b0, multiplier};

    assign accept    = (state == IDLE) && start;
    assign last_step = (state == CALC) && (count == CW'(1));

`ifdef BOOTH_ZERO_SKIP_EN
    assign zero_op = (ext_m == '0) || (ext_q == '0);
`else
    assign zero_op = 1'b0;
`endif

    always_comb begin
        a_sum = a_reg;
        case ({q_reg[0], q_m1})
            2'b01:   a_sum = a_reg + m_reg;
            2'b10:   a_sum = a_reg - m_reg;
            default: a_sum = a_reg;
        endcase
    end

    assign {a_next, q_next, q_m1_next} = {a_sum[DW-1], a_sum, q_reg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = zero_op ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Product is only written at completion so it holds the last result between operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg   <= '0;
            q_reg   <= '0;
            m_reg   <= '0;
            q_m1    <= 1'b0;
            count   <= '0;
            product <= '0;
        end else if (accept) begin
            m_reg <= ext_m;
            q_reg <= ext_q;
            a_reg <= '0;
            q_m1  <= 1'b0;
            count <= STEPS;
            if (zero_op) begin
                product <= '0;
            end
        end else if (state == CALC) begin
            a_reg <= a_next;
            q_reg <= q_next;
            q_m1  <= q_m1_next;
            count <= count - 1'b1;
            if (last_step) begin
                product <= {a_next[WIDTH-2:0], q_next};
            end
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq at WIDTH=8 and WIDTH=16: cycle model plus directed vectors.
// Honours BOOTH_ZERO_SKIP_EN the same way as the design when it is defined.
module tb_booth_mult_seq;

    logic clk;
    logic rst_n;

    logic [1:0]       start_v;
    logic [1:0]       sm_v;
    logic [1:0][31:0] a_v;
    logic [1:0][31:0] b_v;

    logic        busy8, done8, busy16, done16;
    logic [15:0] p8;
    logic [31:0] p16;

    logic [1:0]       busy_v;
    logic [1:0]       done_v;
    logic [1:0][63:0] prod_v;

    assign busy_v    = {busy16, busy8};
    assign done_v    = {done16, done8};
    assign prod_v[0] = {48'd0, p8};
    assign prod_v[1] = {32'd0, p16};

    int n_compared;
    int n_mismatched;

    booth_mult_seq #(.WIDTH(8)) u_dut8 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start_v[0]),
        .signed_mode  (sm_v[0]),
        .multiplicand (a_v[0][7:0]),
        .multiplier   (b_v[0][7:0]),
        .busy         (busy8),
        .done         (done8),
        .product      (p8)
    );

    booth_mult_seq #(.WIDTH(16)) u_dut16 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start_v[1]),
        .signed_mode  (sm_v[1]),
        .multiplicand (a_v[1][15:0]),
        .multiplier   (b_v[1][15:0]),
        .busy         (busy16),
        .done         (done16),
        .product      (p16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int widthOf(input int i);
        return (i == 0) ? 8 : 16;
    endfunction

    function automatic logic [63:0] refProduct(input int w, input logic sm,
                                               input logic [31:0] a, input logic [31:0] b);
        longint av, bv, p;
        logic [63:0] mask;
        av = longint'(a);
        bv = longint'(b);
        if (sm && a[w-1]) av = av - (longint'(1) << w);
        if (sm && b[w-1]) bv = bv - (longint'(1) << w);
        p    = av * bv;
        mask = (64'd1 << (2 * w)) - 64'd1;
        return 64'(p) & mask;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: accept, count down the step latency, then present the arithmetic product.
    logic [1:0]       m_busy;
    logic [1:0]       m_done;
    logic [1:0][63:0] m_prod;
    logic [1:0][63:0] m_pend;
    int               m_rem [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= '0;
            m_done <= '0;
            m_prod <= '0;
            m_pend <= '0;
            for (int i = 0; i < 2; i++) m_rem[i] <= 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_done[i]) begin
                    m_done[i] <= 1'b0;
                    m_busy[i] <= 1'b0;
                end else if (m_busy[i]) begin
                    if (m_rem[i] == 1) begin
                        m_done[i] <= 1'b1;
                        m_prod[i] <= m_pend[i];
                    end
                    m_rem[i] <= m_rem[i] - 1;
                end else if (start_v[i]) begin
                    m_busy[i] <= 1'b1;
                    m_pend[i] <= refProduct(widthOf(i), sm_v[i], a_v[i], b_v[i]);
                    m_rem[i]  <= widthOf(i) + 1;
`ifdef BOOTH_ZERO_SKIP_EN
                    if (a_v[i] == 32'd0 || b_v[i] == 32'd0) begin
                        m_done[i] <= 1'b1;
                        m_prod[i] <= '0;
                    end
`endif
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("busy_w%0d", widthOf(i)), 64'(busy_v[i]), 64'(m_busy[i]));
            checkOutput($sformatf("done_w%0d", widthOf(i)), 64'(done_v[i]), 64'(m_done[i]));
            checkOutput($sformatf("product_w%0d", widthOf(i)), prod_v[i], m_prod[i]);
        end
    end

    // Drive one request and check its product and the edges from acceptance to done.
    task automatic applyStimulus(input int i, input logic sm, input logic [31:0] a,
                                 input logic [31:0] b, input logic [63:0] exp_prod,
                                 input int exp_lat, input string name);
        int lat;
        logic [63:0] res;
        @(negedge clk);
        #1;
        start_v[i] = 1'b1;
        sm_v[i]    = sm;
        a_v[i]     = a;
        b_v[i]     = b;
        @(posedge clk);
        #1;
        start_v[i] = 1'b0;
        a_v[i]     = 32'h5A5A_5A5A & ((32'd1 << widthOf(i)) - 1);
        b_v[i]     = 32'h0000_00C3;
        lat = 0;
        while (!done_v[i] && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = prod_v[i];
        checkOutput({name, "_prod"}, res, exp_prod);
        checkOutput({name, "_lat"}, 64'(lat), 64'(exp_lat));
        @(posedge clk);
        #1;
        checkOutput({name, "_pulse"}, 64'(done_v[i]), 64'd0);
    endtask

    int pulses;
    logic [63:0] seen;

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst_n   = 1'b0;
        start_v = '0;
        sm_v    = '0;
        a_v     = '0;
        b_v     = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", 64'(busy_v), 64'd0);
        checkOutput("reset_done", 64'(done_v), 64'd0);
        checkOutput("reset_prod8", prod_v[0], 64'd0);
        checkOutput("reset_prod16", prod_v[1], 64'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        applyStimulus(0, 1'b1, 32'd10,   32'd5,    64'd50,     9, "s8_10x5");
        applyStimulus(0, 1'b1, 32'hF6,   32'hFB,   64'd50,     9, "s8_m10xm5");
        applyStimulus(0, 1'b1, 32'd10,   32'hFB,   64'hFFCE,   9, "s8_10xm5");
        applyStimulus(0, 1'b1, 32'h80,   32'h80,   64'h4000,   9, "s8_m128xm128");
        applyStimulus(0, 1'b1, 32'hF1,   32'hF0,   64'd240,    9, "s8_m15xm16");
        applyStimulus(0, 1'b0, 32'hFF,   32'hFF,   64'hFE01,   9, "u8_255x255");
        applyStimulus(0, 1'b1, 32'hFF,   32'hFF,   64'h0001,   9, "s8_m1xm1");
        applyStimulus(0, 1'b0, 32'h7F,   32'h80,   64'h3F80,   9, "u8_127x128");
`ifdef BOOTH_ZERO_SKIP_EN
        applyStimulus(0, 1'b1, 32'd0,    32'd77,   64'd0,      0, "s8_0x77");
`else
        applyStimulus(0, 1'b1, 32'd0,    32'd77,   64'd0,      9, "s8_0x77");
`endif

        applyStimulus(1, 1'b1, 32'd10,   32'd5,    64'd50,        17, "s16_10x5");
        applyStimulus(1, 1'b1, 32'hFED4, 32'h04D2, 64'hFFFA_59E8, 17, "s16_m300x1234");
        applyStimulus(1, 1'b1, 32'h8000, 32'h8000, 64'h4000_0000, 17, "s16_min_x_min");
        applyStimulus(1, 1'b0, 32'hFFFF, 32'hFFFF, 64'hFFFE_0001, 17, "u16_max_x_max");

        // A second start during CALC must not disturb the running operation.
        @(negedge clk);
        #1;
        start_v[0] = 1'b1;
        sm_v[0]    = 1'b1;
        a_v[0]     = 32'd11;
        b_v[0]     = 32'd5;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start_v[0] = 1'b1;
        a_v[0]     = 32'd7;
        b_v[0]     = 32'd3;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        pulses = 0;
        seen   = '0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done_v[0]) begin
                pulses++;
                seen = prod_v[0];
            end
        end
        checkOutput("ignore_start_pulses", 64'(pulses), 64'd1);
        checkOutput("ignore_start_prod", seen, 64'd55);

        // Reset in the middle of an operation discards it.
        @(negedge clk);
        #1;
        start_v[0] = 1'b1;
        sm_v[0]    = 1'b1;
        a_v[0]     = 32'd9;
        b_v[0]     = 32'd9;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_busy", 64'(busy_v[0]), 64'd0);
        checkOutput("midreset_done", 64'(done_v[0]), 64'd0);
        checkOutput("midreset_prod", prod_v[0], 64'd0);
        @(negedge clk);
        #1;
        rst_n  = 1'b1;
        pulses = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done_v[0]) pulses++;
        end
        checkOutput("midreset_no_done", 64'(pulses), 64'd0);
        applyStimulus(0, 1'b1, 32'hFD, 32'd6, 64'hFFEE, 9, "s8_after_reset");

        repeat (3) @(posedge clk);
        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
